// File: rtl/serial_unary_reduce_if.sv
// Handshake bundle for serial_unary_reduce: operand offer, result return and busy status.
// The slave modport is the reducer; the master modport is whoever feeds and drains it.
interface serial_unary_reduce_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic         out_c;
  logic         busy;

  modport master (
    output in_valid,
    output in_a,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_c,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_c,
    output busy
  );
endinterface

// File: rtl/serial_unary_reduce.sv
// Serial AND/OR/XOR/XNOR reduction of an N-bit operand, W bits per cycle, LSB chunk first.
// Optional macro SERIAL_UNARY_REDUCE_EARLY_EXIT_EN lets AND/OR finish once the result is decided.
module serial_unary_reduce #(
  parameter int N = 8,
  parameter int W = 1
) (
  input logic            clk,
  input logic            rst_n,
  serial_unary_reduce_if.slave bus
);

  localparam int K  = N / W;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("serial_unary_reduce: W must divide N and satisfy 1 <= W <= N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    a_next;
  logic [KW-1:0]   k;
  logic            acc;
  logic            out_valid_q;
  logic            out_c_q;

  logic [W-1:0]    chunk;
  logic            fold;
  logic            last;
  logic            finish;
  logic            identity;

  // The operand is shifted right each fold, so chunk k always sits in the low W bits.
  assign chunk = a_q[W-1:0];

  generate
    if (W < N) begin : g_shift
      assign a_next = {{W{1'b0}}, a_q[N-1:W]};
    end else begin : g_single
      assign a_next = '0;
    end
  endgenerate

  // XNOR starts from 1 and folds as XOR, which yields the inverted parity.
  assign identity = (bus.in_op == 2'b00) || (bus.in_op == 2'b11);

  always_comb begin
    fold = 1'b0;
    case (op_q)
      2'b00:   fold = acc & (&chunk);
      2'b01:   fold = acc | (|chunk);
      default: fold = acc ^ (^chunk);
    endcase
  end

  assign last = (k == KW'(K - 1));

`ifdef SERIAL_UNARY_REDUCE_EARLY_EXIT_EN
  logic early;
  assign early  = ((op_q == 2'b00) && !(&chunk)) || ((op_q == 2'b01) && (|chunk));
  assign finish = last || early;
`else
  assign finish = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= 2'b00;
      a_q         <= '0;
      k           <= '0;
      acc         <= 1'b0;
      out_valid_q <= 1'b0;
      out_c_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            a_q   <= bus.in_a;
            k     <= '0;
            acc   <= identity;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= fold;
          a_q <= a_next;
          k   <= k + KW'(1);
          if (finish) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_c_q     <= fold;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_c_q     <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          out_c_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;

endmodule

// File: doc/serial_unary_reduce.md
SERIAL_UNARY_REDUCE -- requirements
Module: serial_unary_reduce

Interface
REQ-001 SHALL have parameter N, default 8, the operand width in bits.
REQ-002 SHALL have parameter W, default 1, the bits consumed per cycle; N%W==0 and 1<=W<=N, otherwise elaboration SHALL fail.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand offer.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_a  input  N  operand A.
REQ-008 SHALL have port in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_c  output  1  result C.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready=1; on in_valid&&in_ready the block SHALL capture in_a and in_op, clear chunk counter to 0, preload the accumulator with the op identity (AND/XNOR 1, OR/XOR 0), and enter RUN.
REQ-015 In RUN, each cycle SHALL fold chunk k (bits [k*W+W-1:k*W], LSB chunk first) into the accumulator, then increment k.
REQ-016 After the chunk K-1 fold (K=N/W), the FSM SHALL enter DONE; out_valid SHALL rise exactly K cycles after the accept edge.
REQ-017 XNOR result SHALL be the inverse of the XOR reduction of all N bits; AND/OR/XOR results SHALL equal &, |, ^ of in_a.
REQ-018 In DONE, out_valid=1 and out_c SHALL hold stable until out_valid&&out_ready, after which FSM SHALL return to IDLE on that edge.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_a/in_op changes during RUN SHALL not affect the result.
REQ-020 out_valid SHALL be 0 in IDLE and RUN; out_c SHALL be 0 whenever out_valid is 0.
REQ-021 An operand SHALL not be accepted in the same cycle a result is consumed; next accept is possible one cycle later.
REQ-022 W==N SHALL give a single RUN cycle (latency 1).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, out_c=0, busy=0, counter and accumulator 0, regardless of state.
REQ-024 Reset asserted mid-RUN or in DONE SHALL discard the operation with no out_valid pulse after release.

Configuration
REQ-025 Macro SERIAL_UNARY_REDUCE_EARLY_EXIT_EN defined: in RUN, AND SHALL go to DONE after folding the first chunk containing a 0, OR after the first chunk containing a 1 (out_valid j+1 cycles after accept, j = chunk index); XOR/XNOR unchanged.
REQ-026 Macro undefined: latency SHALL always be exactly K cycles for every op; no early-exit logic present.

Verification (N=8, W=1 unless stated)
REQ-027 AND, in_a=8'hFF, out_ready=1 -> out_c=1, out_valid exactly 8 cycles after accept, in_ready back 1 cycle later.
REQ-028 OR in_a=8'h00 -> out_c=0; OR in_a=8'h80 -> out_c=1; both at 8 cycles.
REQ-029 XOR in_a=8'hA7 -> out_c=1; XNOR in_a=8'hA7 -> out_c=0; W=4 same values at 2 cycles.
REQ-030 out_ready held 0 for 5 cycles in DONE -> out_valid=1, out_c stable, in_ready=0, busy=1 throughout; release on 6th.
REQ-031 rst_n pulsed low 3 cycles after accept -> out_valid/out_c/busy 0 immediately, in_ready=1 after release, no stale result.
REQ-032 AND in_a=8'hFE -> out_c=0 at 1 cycle with SERIAL_UNARY_REDUCE_EARLY_EXIT_EN, at 8 cycles without.
